// File: rtl/alu_cc_pipe.sv
// alu_cc_pipe: registered Y86-64 style ALU (ADD/SUB/AND/XOR) with a one-entry
// valid/ready result stage and the architectural condition-code register
// {ZF,SF,OF} read by cmovXX/jXX in the execute stage.
module alu_cc_pipe #(
  parameter int         WIDTH  = 64,
  parameter logic [2:0] CC_RST = 3'b100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              op,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    set_cc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] result,
  output logic                    out_of,
  output logic                    zf,
  output logic                    sf,
  output logic                    of
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // Signed overflow of a+b: operands share a sign that the result lost.
  function automatic logic add_ovf(input logic s_a, input logic s_b, input logic s_r);
    return (s_a == s_b) && (s_r != s_a);
  endfunction

  // Signed overflow of a-b: operand signs differ and result sign left a's.
  function automatic logic sub_ovf(input logic s_a, input logic s_b, input logic s_r);
    return (s_a != s_b) && (s_r != s_a);
  endfunction

  logic                    r_valid;
  logic signed [WIDTH-1:0] r_result;
  logic                    r_of;
  logic                    r_zf;
  logic                    r_sf;
  logic                    r_cc_of;

  logic signed [WIDTH-1:0] w_res;
  logic                    w_ovf;
  logic                    w_ready;
  logic                    w_fire;

  // The output slot is free when empty or being drained; flush blocks intake.
  assign w_ready = (!r_valid || out_ready) && !flush;
  assign w_fire  = in_valid && w_ready;

  // Operation decode; every op code is covered so no X leaks to the result.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        w_res = a + b;
        w_ovf = add_ovf(a[WIDTH-1], b[WIDTH-1], w_res[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = a - b;
        w_ovf = sub_ovf(a[WIDTH-1], b[WIDTH-1], w_res[WIDTH-1]);
      end
      OP_AND: w_res = a & b;
      OP_XOR: w_res = a ^ b;
      default: begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  // Result stage: load on fire, hold under backpressure, empty on drain/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_of     <= 1'b0;
    end else if (w_fire) begin
      r_valid  <= 1'b1;
      r_result <= w_res;
      r_of     <= w_ovf;
    end else if (flush || out_ready) begin
      r_valid  <= 1'b0;
    end
  end

  // Condition codes follow every fired set_cc op, regardless of downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_zf, r_sf, r_cc_of} <= CC_RST;
    end else if (w_fire && set_cc) begin
      r_zf    <= (w_res == '0);
      r_sf    <= w_res[WIDTH-1];
      r_cc_of <= w_ovf;
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_valid;
  assign result    = r_result;
  assign out_of    = r_of;
  assign zf        = r_zf;
  assign sf        = r_sf;
  assign of        = r_cc_of;

endmodule

// File: tb/tb_alu_cc_pipe.sv
// Bench for alu_cc_pipe: a 64-bit instance exercised with directed vectors
// against a queue-style reference model, and an 8-bit instance streamed with
// back-to-back random operations.
module tb_alu_cc_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // 64-bit instance stimulus/observation
  logic        flush, in_valid, out_ready, set_cc;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic        in_ready, out_valid, out_of, zf, sf, of;
  logic [63:0] result;

  // 8-bit instance stimulus/observation
  logic        flush8, in_valid8, out_ready8, set8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        in_ready8, o8_valid, o8_of, zf8, sf8, of8;
  logic [7:0]  o8_result;

  int checks = 0;
  int errors = 0;

  alu_cc_pipe #(.WIDTH(64), .CC_RST(3'b100)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .set_cc(set_cc), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_of(out_of), .zf(zf), .sf(sf), .of(of)
  );

  alu_cc_pipe #(.WIDTH(8), .CC_RST(3'b100)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
    .op(op8), .a(a8), .b(b8), .set_cc(set8), .out_valid(o8_valid), .out_ready(out_ready8),
    .result(o8_result), .out_of(o8_of), .zf(zf8), .sf(sf8), .of(of8)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: exact signed math in 66 bits, overflow = out of range.
  function automatic void golden(input int w, input logic [1:0] fop, input logic [63:0] fa,
                                 input logic [63:0] fb, output logic [63:0] r, output logic ov);
    logic signed [63:0] sa, sb;
    logic signed [65:0] full, lo, hi;
    logic [63:0] mask;
    sa = $signed(fa << (64 - w)) >>> (64 - w);
    sb = $signed(fb << (64 - w)) >>> (64 - w);
    case (fop)
      2'b00:   full = {{2{sa[63]}}, sa} + {{2{sb[63]}}, sb};
      2'b01:   full = {{2{sa[63]}}, sa} - {{2{sb[63]}}, sb};
      2'b10:   full = {2'b00, sa & sb};
      default: full = {2'b00, sa ^ sb};
    endcase
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    r    = full[63:0] & mask;
    lo   = -(66'sd1 <<< (w - 1));
    hi   = (66'sd1 <<< (w - 1)) - 66'sd1;
    ov   = !fop[1] && ((full < lo) || (full > hi));
  endfunction

  // Model of the 64-bit instance: a one-slot result queue plus the CC register.
  logic        m_valid = 1'b0;
  logic [63:0] m_res = 64'd0;
  logic        m_of = 1'b0;
  logic [2:0]  m_cc = 3'b100;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_valid = 1'b0; m_res = 64'd0; m_of = 1'b0; m_cc = 3'b100;
    end else begin
      logic accept;
      logic [63:0] r;
      logic ov;
      accept = in_valid && !flush && (!m_valid || out_ready);
      if (flush || out_ready) m_valid = 1'b0;   // slot squashed or consumed
      if (accept) begin
        golden(64, op, a, b, r, ov);
        m_valid = 1'b1; m_res = r; m_of = ov;
        if (set_cc) m_cc = {r == 64'd0, r[63], ov};
      end
    end
  end

  // Every-cycle comparison of the 64-bit instance against the model.
  initial forever begin
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("in_ready", 64'(in_ready), 64'((!m_valid || out_ready) && !flush));
    chk("cc", 64'({zf, sf, of}), 64'(m_cc));
    if (m_valid) begin
      chk("result", result, m_res);
      chk("out_of", 64'(out_of), 64'(m_of));
    end
  end

  task automatic drive(input logic [1:0] dop, input logic [63:0] da, input logic [63:0] db,
                       input logic dcc);
    in_valid = 1'b1; op = dop; a = da; b = db; set_cc = dcc;
  endtask

  initial begin
    logic [63:0] gr;
    logic        gov;
    logic [63:0] e_r;
    logic        e_of;
    logic [2:0]  cc8;

    flush = 0; in_valid = 0; out_ready = 1; set_cc = 0; op = 0; a = 0; b = 0;
    flush8 = 0; in_valid8 = 0; out_ready8 = 1; set8 = 0; op8 = 0; a8 = 0; b8 = 0;
    cc8 = 3'b100;

    // Hand-computed pins on the reference arithmetic
    golden(64, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, gr, gov);
    chk("pin_add64_r", gr, 64'h8000_0000_0000_0000); chk("pin_add64_ov", 64'(gov), 64'd1);
    golden(8, 2'b01, 64'h80, 64'h01, gr, gov);
    chk("pin_sub8_r", gr, 64'h7F); chk("pin_sub8_ov", 64'(gov), 64'd1);
    golden(8, 2'b00, 64'hFF, 64'h01, gr, gov);
    chk("pin_add8_r", gr, 64'h00); chk("pin_add8_ov", 64'(gov), 64'd0);
    golden(64, 2'b11, 64'hFF, 64'h0F, gr, gov);
    chk("pin_xor_r", gr, 64'hF0); chk("pin_xor_ov", 64'(gov), 64'd0);

    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_cc", 64'({zf, sf, of}), 64'b100);
    #1 rst_n = 1'b1;

    // ADD overflow
    drive(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    @(negedge clk);
    chk("add_ovf_result", result, 64'h8000_0000_0000_0000);
    chk("add_ovf_of", 64'(out_of), 64'd1);
    chk("add_ovf_cc", 64'({zf, sf, of}), 64'b011);

    // SUB to zero, then AND with set_cc=0
    #1 drive(2'b01, 64'd5, 64'd5, 1'b1);
    @(negedge clk);
    chk("sub_zero_result", result, 64'd0);
    chk("sub_zero_cc", 64'({zf, sf, of}), 64'b100);
    #1 drive(2'b10, 64'hF0, 64'h0F, 1'b0);
    @(negedge clk);
    chk("and_result", result, 64'd0);
    chk("and_cc_hold", 64'({zf, sf, of}), 64'b100);

    // Backpressure
    #1 drive(2'b11, 64'hFF, 64'h0F, 1'b1);
    @(negedge clk);
    chk("xor_result", result, 64'hF0);
    chk("xor_cc", 64'({zf, sf, of}), 64'b000);
    #1 out_ready = 1'b0; drive(2'b00, 64'd1, 64'd2, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_result", result, 64'hF0);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    #1 out_ready = 1'b1;
    #1 chk("release_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("release_result", result, 64'd3);

    // Flush while stalled
    #1 drive(2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
    @(negedge clk);
    chk("sub_ovf_result", result, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("sub_ovf_cc", 64'({zf, sf, of}), 64'b001);
    #1 out_ready = 1'b0; flush = 1'b1; drive(2'b00, 64'd4, 64'd4, 1'b1);
    #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_cc_kept", 64'({zf, sf, of}), 64'b001);
    #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);

    // Flush together with out_ready
    #1 drive(2'b00, 64'd4, 64'd4, 1'b1);
    @(negedge clk);
    chk("add8_result", result, 64'd8);
    #1 flush = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_rdy_valid", 64'(out_valid), 64'd0);
    #1 flush = 1'b0;

    // Asynchronous reset mid-stream
    drive(2'b11, 64'd3, 64'd1, 1'b1);
    @(negedge clk);
    chk("pre_rst_result", result, 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_result", result, 64'd0);
    chk("async_rst_cc", 64'({zf, sf, of}), 64'b100);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Streaming on the 8-bit instance: one result per cycle, latency 1
    for (int i = 0; i <= 256; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("s8_valid", 64'(o8_valid), 64'd1);
        chk("s8_result", 64'(o8_result), 64'(e_r[7:0]));
        chk("s8_of", 64'(o8_of), 64'(e_of));
        chk("s8_cc", 64'({zf8, sf8, of8}), 64'(cc8));
      end
      chk("s8_in_ready", 64'(in_ready8), 64'd1);
      #1;
      if (i < 256) begin
        in_valid8 = 1'b1;
        op8  = 2'($urandom_range(3));
        a8   = 8'($urandom_range(255));
        b8   = 8'($urandom_range(255));
        set8 = 1'($urandom_range(1));
        if (i == 0) begin op8 = 2'b00; a8 = 8'h7F; b8 = 8'h01; set8 = 1'b1; end
        golden(8, op8, {56'd0, a8}, {56'd0, b8}, e_r, e_of);
        if (set8) cc8 = {e_r[7:0] == 8'd0, e_r[7], e_of};
      end else begin
        in_valid8 = 1'b0;
      end
    end
    @(negedge clk);
    chk("s8_drained", 64'(o8_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
